dram_port_arbiter: RTL and testbench

- Parametrised N-port arbiter that multiplexes several DRAM requesters onto the single request/response interface of sdram_controller3.
- Requesters include the core, a future video fetch unit and a DMA engine.
- Sits between requesters and the controller, in the clk (50 MHz) domain.
- Adds selectable fixed-priority or round-robin arbitration, per-port response routing, and a response timeout; none of these exist with a single directly-wired requester.

---
 rtl/dram_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_dram_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// N-port request arbiter in front of the single-requester SDRAM controller.
// One transaction at a time: IDLE picks a port, BUSY waits for the response, RELEASE idles for one cycle.
module dram_port_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0,
    parameter int TIMEOUT    = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           s_req_read,
    input  logic [NUM_PORTS-1:0]           s_req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_wdata,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [NUM_PORTS-1:0]           s_data_valid,
    output logic [NUM_PORTS-1:0]           s_write_complete,
    output logic [NUM_PORTS-1:0]           s_error,
    output logic                           m_req_read,
    output logic                           m_req_write,
    output logic [ADDR_WIDTH-1:0]          m_addr,
    output logic [DATA_WIDTH-1:0]          m_wdata,
    input  logic [DATA_WIDTH-1:0]          m_rdata,
    input  logic                           m_data_valid,
    input  logic                           m_write_complete,
    output logic [2:0]                     grant_idx
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [2:0] RR_INIT = 3'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t                 state, state_n;
    logic [2:0]             rr_ptr, rr_n;
    logic [CW-1:0]          tmo_cnt, tmo_n;
    logic                   req_rd_n, req_wr_n;
    logic [ADDR_WIDTH-1:0]  addr_n;
    logic [DATA_WIDTH-1:0]  wdata_n, rdata_n;
    logic [NUM_PORTS-1:0]   dv_n, wc_n, err_n, grant_oh;
    logic [2:0]             grant_n;

    logic [7:0]             pend8, wr8;
    logic                   win_valid;
    logic [2:0]             win_idx, cand;

    assign grant_oh = NUM_PORTS'(1) << grant_idx;

    // Round robin scans starting one past the last winner; fixed mode scans from port 0.
    always_comb begin
        pend8     = 8'(s_req_read | s_req_write);
        wr8       = 8'(s_req_write);
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (ARB_MODE == 0) cand = 3'(k);
            else               cand = 3'((int'(rr_ptr) + 1 + k) % NUM_PORTS);
            if (!win_valid && pend8[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_n  = state;
        req_rd_n = m_req_read;
        req_wr_n = m_req_write;
        addr_n   = m_addr;
        wdata_n  = m_wdata;
        rdata_n  = s_rdata;
        dv_n     = '0;
        wc_n     = '0;
        err_n    = '0;
        grant_n  = grant_idx;
        rr_n     = rr_ptr;
        tmo_n    = tmo_cnt;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    addr_n   = s_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_n  = s_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    req_wr_n = wr8[win_idx];
                    req_rd_n = !wr8[win_idx];
                    grant_n  = win_idx;
                    rr_n     = win_idx;
                    tmo_n    = '0;
                    state_n  = BUSY;
                end
            end
            BUSY: begin
                tmo_n = tmo_cnt + CW'(1);
                // A matching response takes precedence over a timeout on the same cycle.
                if (m_req_read && m_data_valid) begin
                    rdata_n  = m_rdata;
                    dv_n     = grant_oh;
                    req_rd_n = 1'b0;
                    state_n  = RELEASE;
                end else if (m_req_write && m_write_complete) begin
                    wc_n     = grant_oh;
                    req_wr_n = 1'b0;
                    state_n  = RELEASE;
                end else if (TIMEOUT != 0 && tmo_cnt == TO_LAST) begin
                    err_n    = grant_oh;
                    req_rd_n = 1'b0;
                    req_wr_n = 1'b0;
                    state_n  = RELEASE;
                end
            end
            RELEASE: begin
                tmo_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            m_req_read       <= 1'b0;
            m_req_write      <= 1'b0;
            m_addr           <= '0;
            m_wdata          <= '0;
            s_rdata          <= '0;
            s_data_valid     <= '0;
            s_write_complete <= '0;
            s_error          <= '0;
            grant_idx        <= '0;
            rr_ptr           <= RR_INIT;
            tmo_cnt          <= '0;
        end else begin
            state            <= state_n;
            m_req_read       <= req_rd_n;
            m_req_write      <= req_wr_n;
            m_addr           <= addr_n;
            m_wdata          <= wdata_n;
            s_rdata          <= rdata_n;
            s_data_valid     <= dv_n;
            s_write_complete <= wc_n;
            s_error          <= err_n;
            grant_idx        <= grant_n;
            rr_ptr           <= rr_n;
            tmo_cnt          <= tmo_n;
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter and a 3-port round-robin arbiter
// share one hand-driven controller stub; only the instance with a live request reacts.
module tb_dram_port_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    logic [DW-1:0] m_rdata;
    logic          m_data_valid, m_write_complete;

    logic [1:0]      a_req_read, a_req_write, a_dv, a_wc, a_err;
    logic [2*AW-1:0] a_addr;
    logic [2*DW-1:0] a_wdata;
    logic [DW-1:0]   a_rdata, a_m_wdata;
    logic            a_m_rd, a_m_wr;
    logic [AW-1:0]   a_m_addr;
    logic [2:0]      a_grant;

    logic [2:0]      b_req_read, b_req_write, b_dv, b_wc, b_err;
    logic [3*AW-1:0] b_addr;
    logic [3*DW-1:0] b_wdata;
    logic [DW-1:0]   b_rdata, b_m_wdata;
    logic            b_m_rd, b_m_wr;
    logic [AW-1:0]   b_m_addr;
    logic [2:0]      b_grant;

    dram_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_req_read(a_req_read), .s_req_write(a_req_write), .s_addr(a_addr), .s_wdata(a_wdata),
        .s_rdata(a_rdata), .s_data_valid(a_dv), .s_write_complete(a_wc), .s_error(a_err),
        .m_req_read(a_m_rd), .m_req_write(a_m_wr), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
        .m_rdata(m_rdata), .m_data_valid(m_data_valid), .m_write_complete(m_write_complete),
        .grant_idx(a_grant)
    );

    dram_port_arbiter #(.NUM_PORTS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_req_read(b_req_read), .s_req_write(b_req_write), .s_addr(b_addr), .s_wdata(b_wdata),
        .s_rdata(b_rdata), .s_data_valid(b_dv), .s_write_complete(b_wc), .s_error(b_err),
        .m_req_read(b_m_rd), .m_req_write(b_m_wr), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
        .m_rdata(m_rdata), .m_data_valid(m_data_valid), .m_write_complete(m_write_complete),
        .grant_idx(b_grant)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] stub_mem;
    logic [2:0]    exp_oh;
    int            exp_g [6] = '{0, 1, 2, 0, 1, 2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller stub: read data strobe lands 'lat' edges after the grant edge.
    task automatic resp_read(input int lat, input logic [DW-1:0] d);
        repeat (lat - 1) tick();
        m_data_valid = 1'b1;
        m_rdata      = d;
        tick();
        m_data_valid = 1'b0;
    endtask

    initial begin
        m_rdata = '0; m_data_valid = 1'b0; m_write_complete = 1'b0;
        a_req_read = '0; a_req_write = '0; a_addr = '0; a_wdata = '0;
        b_req_read = '0; b_req_write = '0; b_addr = '0; b_wdata = '0;
        stub_mem = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_req", {a_m_rd, a_m_wr, b_m_rd, b_m_wr}, 0);
        check("rst_m_addr", a_m_addr, 0);
        check("rst_m_wdata", a_m_wdata, 0);
        check("rst_s_rdata", a_rdata, 0);
        check("rst_pulses", {a_dv, a_wc, a_err, b_dv, b_wc, b_err}, 0);
        check("rst_grant", {a_grant, b_grant}, 0);
        rst_n = 1'b1;
        tick();

        // single read on port 0
        a_addr[0 +: AW] = 24'h000123;
        a_req_read = 2'b01;
        tick();
        check("rd_req_latency", a_m_rd, 1);
        check("rd_addr", a_m_addr, 24'h000123);
        check("rd_grant", a_grant, 0);
        resp_read(6, 32'hDEADBEEF);
        check("rd_dv", a_dv, 2'b01);
        check("rd_data", a_rdata, 32'hDEADBEEF);
        check("rd_req_drop", a_m_rd, 0);
        a_req_read = 2'b00;
        tick();
        check("rd_dv_one_cycle", a_dv, 2'b00);
        check("rd_release_low", a_m_rd, 0);
        tick();
        check("rd_idle_low", a_m_rd, 0);

        // read+write on one port: write wins; mismatched strobe ignored
        a_addr[0 +: AW] = 24'h000010;
        a_wdata[0 +: DW] = 32'hAAAA5555;
        a_req_read = 2'b01;
        a_req_write = 2'b01;
        tick();
        check("ww_m_wr", a_m_wr, 1);
        check("ww_m_rd", a_m_rd, 0);
        check("ww_wdata", a_m_wdata, 32'hAAAA5555);
        m_rdata = 32'h0;
        m_data_valid = 1'b1;
        tick();
        m_data_valid = 1'b0;
        check("mismatch_no_dv", a_dv, 2'b00);
        check("mismatch_hold_wr", a_m_wr, 1);
        m_write_complete = 1'b1;
        tick();
        m_write_complete = 1'b0;
        check("ww_wc", a_wc, 2'b01);
        check("ww_rdata_held", a_rdata, 32'hDEADBEEF);
        a_req_read = 2'b00;
        a_req_write = 2'b00;
        tick();

        // fixed priority: port 0 keeps winning while it requests
        a_addr[0 +: AW] = 24'h000100;
        a_addr[AW +: AW] = 24'h000200;
        a_req_read = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fp_grant", a_grant, 0);
            check("fp_addr", a_m_addr, 24'h000100);
            resp_read(2, 32'h100 + i);
            check("fp_dv", a_dv, 2'b01);
            check("fp_data", a_rdata, 32'h100 + i);
            a_req_read = (i == 3) ? 2'b10 : 2'b11;
            tick();
        end
        tick();
        check("fp_p1_grant", a_grant, 1);
        check("fp_p1_addr", a_m_addr, 24'h000200);
        resp_read(3, 32'hCAFEF00D);
        check("fp_p1_dv", a_dv, 2'b10);
        check("fp_p1_data", a_rdata, 32'hCAFEF00D);
        a_req_read = 2'b00;
        tick();

        // round robin over 3 ports
        b_addr[0 +: AW] = 24'h00A000;
        b_addr[AW +: AW] = 24'h00A001;
        b_addr[2*AW +: AW] = 24'h00A002;
        b_req_read = 3'b111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_grant", b_grant, exp_g[i]);
            check("rr_addr", b_m_addr, 24'h00A000 + exp_g[i]);
            resp_read(2, 32'h55 + i);
            exp_oh = 3'b001 << exp_g[i];
            check("rr_dv", b_dv, exp_oh);
            tick();
        end
        b_req_read = 3'b000;
        tick();

        // port 1 writes, port 0 reads back through the stub memory
        a_addr[AW +: AW] = 24'h00ABCD;
        a_wdata[DW +: DW] = 32'h12345678;
        a_req_write = 2'b10;
        tick();
        check("wr_grant", a_grant, 1);
        check("wr_m_wr", a_m_wr, 1);
        check("wr_addr", a_m_addr, 24'h00ABCD);
        check("wr_wdata", a_m_wdata, 32'h12345678);
        stub_mem = a_m_wdata;
        repeat (3) tick();
        m_write_complete = 1'b1;
        tick();
        m_write_complete = 1'b0;
        check("wr_wc", a_wc, 2'b10);
        check("wr_no_dv", a_dv, 2'b00);
        a_req_write = 2'b00;
        tick();
        a_addr[0 +: AW] = 24'h00ABCD;
        a_req_read = 2'b01;
        tick();
        check("wr_rd_grant", a_grant, 0);
        check("wr_rd_addr", a_m_addr, 24'h00ABCD);
        resp_read(4, stub_mem);
        check("wr_rd_dv", a_dv, 2'b01);
        check("wr_rd_data", a_rdata, 32'h12345678);
        a_req_read = 2'b00;
        tick();

        // timeout with no response, then port 1 is served
        a_addr[0 +: AW] = 24'h000300;
        a_addr[AW +: AW] = 24'h000400;
        a_req_read = 2'b11;
        tick();
        check("to_grant", a_grant, 0);
        repeat (15) tick();
        check("to_not_yet", a_err, 2'b00);
        check("to_req_held", a_m_rd, 1);
        tick();
        check("to_err", a_err, 2'b01);
        check("to_req_drop", a_m_rd, 0);
        check("to_no_dv", a_dv, 2'b00);
        a_req_read = 2'b10;
        tick();
        check("to_release_low", a_m_rd, 0);
        check("to_err_one_cycle", a_err, 2'b00);
        tick();
        check("to_next_grant", a_grant, 1);
        check("to_next_req", a_m_rd, 1);
        check("to_next_addr", a_m_addr, 24'h000400);
        resp_read(2, 32'h00000077);
        check("to_next_dv", a_dv, 2'b10);
        a_req_read = 2'b00;
        tick();

        // response on the timeout cycle wins
        a_req_read = 2'b01;
        tick();
        repeat (15) tick();
        m_data_valid = 1'b1;
        m_rdata = 32'h5A5A5A5A;
        tick();
        m_data_valid = 1'b0;
        check("race_dv", a_dv, 2'b01);
        check("race_no_err", a_err, 2'b00);
        check("race_data", a_rdata, 32'h5A5A5A5A);
        a_req_read = 2'b00;
        tick();

        // asynchronous reset in the middle of a read
        a_addr[0 +: AW] = 24'h000555;
        a_req_read = 2'b01;
        tick();
        check("mr_req", a_m_rd, 1);
        repeat (3) tick();
        a_req_read = 2'b11;
        #3;
        rst_n = 1'b0;
        #1;
        check("mr_req_drop", a_m_rd, 0);
        check("mr_addr_clr", a_m_addr, 0);
        check("mr_rdata_clr", a_rdata, 0);
        check("mr_pulses_clr", {a_dv, a_wc, a_err}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_regrant", a_grant, 0);
        check("mr_regrant_req", a_m_rd, 1);
        check("mr_regrant_addr", a_m_addr, 24'h000555);
        resp_read(2, 32'h1);
        check("mr_done_dv", a_dv, 2'b01);
        a_req_read = 2'b00;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
